// File: rtl/sseg_display_arbiter.sv
// Round-robin arbiter that hands the six-digit display to one hardware requester at a time,
// with a minimum hold time, optional blinking and leading-zero blanking on the alternate inputs.
module sseg_display_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 25_000_000,
    parameter int BLINK_HALF  = 6_250_000,
    parameter bit LZ_SUPPRESS = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req,
    input  logic [32*NREQ-1:0]   i_data,
    input  logic [NREQ-1:0]      i_blink,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_alt_sel,
    output logic [31:0]          o_alt_data,
    output logic [5:0]           o_alt_en
);

    localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_HALF + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SHOW = 1'b1;

    logic [0:0]         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    logic [0:0]         nxt_state;
    logic [IDX_W-1:0]   nxt_owner;
    logic [HOLD_W-1:0]  nxt_hold;
    logic [BLINK_W-1:0] nxt_bcnt;
    logic               nxt_bon;
    logic               new_grant;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [NREQ-1:0]    nxt_grant;
    logic [31:0]        nxt_data;

    // Digits above the most significant nonzero nibble are blanked; digit 0 always stays lit.
    function automatic logic [5:0] digit_mask(input logic [23:0] v);
        logic [5:0] m;
        if (LZ_SUPPRESS == 1'b0) begin
            m = 6'h3f;
        end else begin
            m = 6'h01;
            for (int d = 1; d < 6; d++) begin
                if (v[4*d +: 4] != 4'h0) m = 6'h3f >> (5 - d);
            end
        end
        return m;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] r;
        if (int'(i) == NREQ - 1) r = '0;
        else                     r = i + 1'b1;
        return r;
    endfunction

    // First requester at or above ptr, wrapping; scanning downward leaves the nearest one.
    function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IDX_W-1:0] ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               k;
        found = 1'b0;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NREQ;
            if (req[k]) begin
                found = 1'b1;
                idx   = IDX_W'(k);
            end
        end
        return {found, idx};
    endfunction

    // Next-state decision: release, hold countdown, rotation on expiry, blink phase.
    always_comb begin
        nxt_state = state;
        nxt_owner = owner;
        nxt_hold  = hold_cnt;
        nxt_bcnt  = blink_cnt;
        nxt_bon   = blink_on;
        new_grant = 1'b0;
        {pick_found, pick_idx} = rr_pick(i_req & ~o_grant, rr_ptr);

        if (state == S_IDLE) begin
            if (pick_found) new_grant = 1'b1;
        end else if (!i_req[owner]) begin
            if (pick_found) new_grant = 1'b1;
            else            nxt_state = S_IDLE;
        end else begin
            if (hold_cnt != '0)  nxt_hold = hold_cnt - 1'b1;
            else if (pick_found) new_grant = 1'b1;
            else                 nxt_hold = HOLD_LOAD;

            if (i_blink[owner]) begin
                if (blink_cnt == BLINK_LAST) begin
                    nxt_bcnt = '0;
                    nxt_bon  = ~blink_on;
                end else begin
                    nxt_bcnt = blink_cnt + 1'b1;
                end
            end else begin
                nxt_bcnt = '0;
                nxt_bon  = 1'b1;
            end
        end

        if (new_grant) begin
            nxt_state = S_SHOW;
            nxt_owner = pick_idx;
            nxt_hold  = HOLD_LOAD;
            nxt_bcnt  = '0;
            nxt_bon   = 1'b1;
        end

        nxt_grant            = '0;
        nxt_grant[nxt_owner] = 1'b1;
        nxt_data             = i_data[32*int'(nxt_owner) +: 32];
    end

    // Registered state and display outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= S_IDLE;
            owner      <= '0;
            rr_ptr     <= '0;
            hold_cnt   <= '0;
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
            o_grant    <= '0;
            o_alt_sel  <= 1'b0;
            o_alt_data <= '0;
            o_alt_en   <= '0;
        end else begin
            state     <= nxt_state;
            owner     <= nxt_owner;
            hold_cnt  <= nxt_hold;
            blink_cnt <= nxt_bcnt;
            blink_on  <= nxt_bon;
            if (new_grant) rr_ptr <= wrap_inc(pick_idx);

            if (nxt_state == S_SHOW) begin
                o_grant    <= nxt_grant;
                o_alt_sel  <= 1'b1;
                o_alt_data <= nxt_data;
                o_alt_en   <= nxt_bon ? digit_mask(nxt_data[23:0]) : 6'h00;
            end else begin
                o_grant   <= '0;
                o_alt_sel <= 1'b0;
                o_alt_en  <= '0;
            end
        end
    end

endmodule
